pc_gen: RTL

- Parametrised fetch-address generator: successor to the single-branch PC register at the front of the IF stage.
- Produces the instruction-fetch address and fetch enable.
- Arbitrates NUM_REDIR prioritised redirect channels (e.g. trap, EX branch, ID jump).
- Holds a redirect that arrives while fetch is stalled so it is never lost.
- Optionally predicts taken branches with a small direct-mapped BTB.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen_btb.sv | 73 +++++++
 rtl/pc_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared defaults and types for the IF-stage fetch-address generator.
package pc_gen_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_0000;
    localparam int unsigned INST_BYTES_DEF = 4;
    // Position of the IF stage in the pipeline stall vector.
    localparam int unsigned STALL_IF_BIT   = 0;

    // Source of the next fetch address.
    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_LIVE,
        NPC_PEND,
        NPC_BTB,
        NPC_SEQ
    } npc_src_e;

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the current pc,
// update written at the clock edge (a same-cycle update is seen next cycle).
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned INST_BYTES = INST_BYTES_DEF,
    parameter int unsigned BTB_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lkp_pc_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_taken_i
);

    localparam int unsigned OFF_W = $clog2(INST_BYTES);
    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

    logic [BTB_DEPTH-1:0] vld_q;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_tag_match;

    assign lkp_idx       = lkp_pc_i[OFF_W +: IDX_W];
    assign lkp_tag       = lkp_pc_i[ADDR_W-1 -: TAG_W];
    assign upd_idx       = upd_pc_i[OFF_W +: IDX_W];
    assign upd_tag       = upd_pc_i[ADDR_W-1 -: TAG_W];
    assign upd_tag_match = (tag_q[upd_idx] == upd_tag);

    assign hit_o    = vld_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign target_o = tgt_q[lkp_idx];

    // Byte-offset bits never take part in indexing or tagging.
    generate
        if (OFF_W > 0) begin : g_off
            logic unused_off;
            assign unused_off = ^{lkp_pc_i[OFF_W-1:0], upd_pc_i[OFF_W-1:0]};
        end
    endgenerate

    // Valid bits: install on taken, invalidate only on a matching not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                vld_q[upd_idx] <= 1'b1;
            end else if (upd_tag_match) begin
                vld_q[upd_idx] <= 1'b0;
            end
        end
    end

    // Tag and target payload; meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (upd_valid_i && upd_taken_i) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator for the IF stage: prioritised redirect channels,
// one-entry pending buffer for redirects that arrive while stalled, and an
// optional BTB predictor enabled with the PC_GEN_BTB_EN macro.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
    parameter int unsigned       INST_BYTES = INST_BYTES_DEF,
    parameter int unsigned       STALL_W    = 5,
    parameter int unsigned       NUM_REDIR  = 2,
    parameter int unsigned       BTB_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STALL_W-1:0]          stall_i,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
    input  logic                        btb_upd_valid_i,
    input  logic [ADDR_W-1:0]           btb_upd_pc_i,
    input  logic [ADDR_W-1:0]           btb_upd_target_i,
    input  logic                        btb_upd_taken_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        ce_o,
    output logic                        pred_taken_o,
    output logic                        misalign_o
);

    localparam int unsigned       CH_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pred_q, pred_d;
    logic              mis_q, mis_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;

    logic              adv;
    logic              live_any;
    logic [CH_W-1:0]   live_ch;
    logic [ADDR_W-1:0] live_addr;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_tgt;
    logic [ADDR_W-1:0] redir_tgt;
    npc_src_e          npc_src;

    logic unused_stall;
    assign unused_stall = ^stall_i;

    assign adv = ce_q & ~stall_i[STALL_IF_BIT];

`ifdef PC_GEN_BTB_EN
    pc_gen_btb #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .BTB_DEPTH  (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc_i     (pc_q),
        .hit_o        (btb_hit),
        .target_o     (btb_tgt),
        .upd_valid_i  (btb_upd_valid_i),
        .upd_pc_i     (btb_upd_pc_i),
        .upd_target_i (btb_upd_target_i),
        .upd_taken_i  (btb_upd_taken_i)
    );
`else
    logic unused_btb;
    assign unused_btb = ^{btb_upd_valid_i, btb_upd_pc_i, btb_upd_target_i, btb_upd_taken_i};
    assign btb_hit    = 1'b0;
    assign btb_tgt    = '0;
`endif

    // Live redirect arbitration: scan from lowest priority so index 0 wins.
    always_comb begin
        live_any  = 1'b0;
        live_ch   = '0;
        live_addr = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                live_any  = 1'b1;
                live_ch   = CH_W'(k);
                live_addr = redir_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-pc selection, pending-buffer maintenance and misalign pulse.
    always_comb begin
        pc_d        = pc_q;
        ce_d        = 1'b1;
        pred_d      = pred_q;
        mis_d       = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_ch_d   = pend_ch_q;
        redir_tgt   = '0;
        npc_src     = NPC_HOLD;

        if (adv) begin
            if (live_any) begin
                npc_src   = NPC_LIVE;
                redir_tgt = live_addr;
            end else if (pend_vld_q) begin
                npc_src   = NPC_PEND;
                redir_tgt = pend_addr_q;
            end else if (btb_hit) begin
                npc_src = NPC_BTB;
            end else begin
                npc_src = NPC_SEQ;
            end
        end

        case (npc_src)
            NPC_LIVE, NPC_PEND: begin
                pc_d       = redir_tgt & ~OFF_MASK;
                mis_d      = |(redir_tgt & OFF_MASK);
                pred_d     = 1'b0;
                pend_vld_d = 1'b0;
            end
            NPC_BTB: begin
                pc_d   = btb_tgt;
                pred_d = 1'b1;
            end
            NPC_SEQ: begin
                pc_d   = pc_q + PC_INC;
                pred_d = 1'b0;
            end
            default: begin
                // Stalled: capture a redirect unless a stronger one is already held.
                if (live_any && (!pend_vld_q || (live_ch < pend_ch_q))) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = live_addr;
                    pend_ch_d   = live_ch;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            ce_q        <= 1'b0;
            pred_q      <= 1'b0;
            mis_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_ch_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pred_q      <= pred_d;
            mis_q       <= mis_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_ch_q   <= pend_ch_d;
        end
    end

    assign pc_o         = pc_q;
    assign ce_o         = ce_q;
    assign pred_taken_o = pred_q;
    assign misalign_o   = mis_q;

endmodule
